rvc_fetch_aligner: RTL and testbench
====================================

# rvc_fetch_aligner

Instruction-fetch aligner for the RV32IC pipeline. It sits between the instruction memory port (32-bit, word-aligned, one outstanding read) and the decode stage. It reassembles the halfword-aligned instruction stream into whole instructions: 16-bit compressed instructions, 32-bit instructions aligned to a word, and 32-bit instructions that straddle a word boundary. Each instruction is presented to decode with its PC and a compressed flag over a valid/ready handshake, and a redirect from the branch/jump resolution logic restarts the fetch stream.

## Interface
- RESET_PC, 32'h00000060, PC of the first instruction after reset; must be halfword-aligned.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- imem_read  output  1  read request; held high until imem_resp.
- imem_addr  output  32  word address of the request; bits [1:0] are always 0 and the value is stable while imem_read is high.
- imem_rdata  input  32  read data; valid only in the imem_resp cycle.
- imem_resp  input  1  single-cycle read completion.
- redirect  input  1  single-cycle pulse that restarts fetch at redirect_pc.
- redirect_pc  input  32  target PC; bit 0 is ignored.
- instr_valid  output  1  instr, instr_pc and instr_is_c are valid.
- instr_ready  input  1  decode accepts the instruction on an edge where valid && ready.
- instr  output  32  the instruction; a compressed instruction is zero-extended as {16'h0, half}.
- instr_pc  output  32  PC of instr.
- instr_is_c  output  1  1 when instr[1:0] != 2'b11.

## Operation
- Internal state:
  - fetch_addr: word-aligned address of the next read.
  - hb[15:0] with hb_valid and hb_pc: the buffered upper halfword.
  - skip_low: set after a redirect to an odd halfword.
  - drop: a flush is pending against an outstanding read.
  - FSM state.
- FSM states:
  - FETCH: imem_read=1.
  - EMIT: instr_valid=1, waiting for ready.
  - NEXT: decision cycle, internal only, no outputs asserted.
  - An implementation may fold NEXT into the accept edge, but the throughput below is mandatory.
- A half h is compressed iff h[1:0] != 2'b11.
- Next-instruction decision, taken at the EMIT-accept edge or after reset/redirect:
  - A, buffered compressed: hb_valid && hb compressed. Emit {16'h0, hb} at hb_pc, clear hb_valid, no read.
  - B, buffered upper half of a 32-bit instruction: hb_valid && !compressed. Go to FETCH at fetch_addr. On response w, emit {w[15:0], hb} at hb_pc, load hb←w[31:16] with hb_pc←fetch_addr+2 and hb_valid←1, then fetch_addr+=4.
  - C, empty buffer: go to FETCH. On response w, fetch_addr+=4.
    - If skip_low: clear skip_low, load hb←w[31:16], then apply A or B. B in this case issues a further read.
    - Else, if w[15:0] is compressed: emit {16'h0, w[15:0]}, load hb←w[31:16] valid.
    - Else: emit w, hb invalid.
- PC arithmetic is modulo 2^32, so fetch_addr wraps from 32'hFFFFFFFC to 0.
- Redirect (highest priority, any state):
  - Clears hb_valid and sets fetch_addr←{redirect_pc[31:2], 2'b00}, skip_low←redirect_pc[1], drops instr_valid, and enters FETCH.
  - If a read is outstanding with no imem_resp in the redirect cycle: set drop, keep imem_read and imem_addr unchanged until imem_resp, discard that data, then issue the new read.
  - Redirect in the same cycle as imem_resp: the data is discarded.
  - Redirect with instr_valid && instr_ready in the same cycle: the flush wins and the block emits nothing more from the old stream.
- Reset mid-operation: all state returns to reset values, and any pending response that arrives afterwards is ignored (imem_read was low).

## Timing
- Reset values:
  - imem_read=0, imem_addr={RESET_PC[31:2], 2'b00}.
  - instr_valid=0, instr=0, instr_pc=0, instr_is_c=0.
  - hb_valid=0, skip_low=RESET_PC[1], drop=0.
- imem_read rises in the first cycle after rst deasserts.
- All outputs are registered.
- instr_valid rises in the cycle after imem_resp (1-cycle response-to-valid latency).
- Case A is issued at the accept edge, so instr_valid stays high back-to-back: two compressed instructions from one word take consecutive cycles.
- Case B/C: imem_read is high in the cycle after accept.
- While instr_valid && !instr_ready:
  - instr, instr_pc and instr_is_c are stable.
  - No read is issued.
- instr_valid drops in the cycle after redirect.
- At most one read is outstanding at any time.

## Test plan
- Aligned 32-bit: reset, word @0x60 = 0x00A00093, 1-cycle response, ready=1 → instr=0x00A00093, instr_pc=0x60, is_c=0. Next read is 0x64.
- Two compressed instructions in one word: @0x60 = 0x45854505 → 0x00004505 @0x60, then 0x00004585 @0x62 on the next cycle, with no read between. Next read is 0x64.
- Straddling 32-bit: @0x60 = 0x00934505 and @0x64 = 0x458500A0 → 0x4505 @0x60, then 0x00A00093 @0x62, then 0x4585 @0x66. Exactly 2 reads.
- Odd redirect: redirect_pc = 0x103 with @0x100 = 0x4505FFFF → read 0x100, low half discarded, emit 0x4505 @0x102.
- Redirect during outstanding read: redirect to 0x200 while the 0x64 read is pending with 4-cycle latency → imem_addr holds 0x64 until resp, data discarded, next read 0x200. No instr_valid from the 0x64 data.
- Backpressure: instr_ready low for 5 cycles while valid → outputs constant, imem_read=0 throughout, and the instruction is accepted on the 6th cycle.

Source files
------------

// File: rtl/rvc_fetch_aligner.sv
// RV32IC fetch aligner: rebuilds compressed, aligned and word-straddling instructions from a 32-bit imem port.
// One read outstanding at a time; response-to-valid is 1 cycle; decode backpressure holds the output and blocks new reads.
module rvc_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_is_c
);

    typedef enum logic [1:0] {S_FETCH, S_EMIT, S_NEXT} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [15:0] hb_q, hb_d;
    logic [31:0] hb_pc_q, hb_pc_d;
    logic        hb_valid_q, hb_valid_d;
    logic        skip_low_q, skip_low_d;
    logic        drop_q, drop_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_is_c_q, instr_is_c_d;
    logic        emit;
    logic [31:0] redir_word;

    function automatic logic half_is_c(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    assign redir_word = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pend_addr_d  = pend_addr_q;
        hb_d         = hb_q;
        hb_pc_d      = hb_pc_q;
        hb_valid_d   = hb_valid_q;
        skip_low_d   = skip_low_q;
        drop_d       = drop_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        instr_is_c_d = instr_is_c_q;
        emit         = 1'b0;

        if (redirect) begin
            state_d    = S_FETCH;
            hb_valid_d = 1'b0;
            skip_low_d = (redirect_pc[1:0] >= 2'd2);
            // An unanswered read keeps its address on the bus; the target waits in pend_addr.
            if (state_q == S_FETCH && !imem_resp) begin
                drop_d      = 1'b1;
                pend_addr_d = redir_word;
            end else begin
                drop_d       = 1'b0;
                fetch_addr_d = redir_word;
            end
        end else if (state_q == S_NEXT || (state_q == S_EMIT && instr_ready)) begin
            if (hb_valid_q && half_is_c(hb_q)) begin
                emit       = 1'b1;
                instr_d    = {16'h0, hb_q};
                instr_pc_d = hb_pc_q;
                hb_valid_d = 1'b0;
                state_d    = S_EMIT;
            end else begin
                state_d = S_FETCH;
            end
        end else if (state_q == S_FETCH && imem_resp) begin
            if (drop_q) begin
                drop_d       = 1'b0;
                fetch_addr_d = pend_addr_q;
            end else begin
                fetch_addr_d = fetch_addr_q + 32'd4;
                hb_d         = imem_rdata[31:16];
                hb_pc_d      = fetch_addr_q + 32'd2;
                if (hb_valid_q) begin
                    emit       = 1'b1;
                    instr_d    = {imem_rdata[15:0], hb_q};
                    instr_pc_d = hb_pc_q;
                    hb_valid_d = 1'b1;
                    state_d    = S_EMIT;
                end else if (skip_low_q) begin
                    skip_low_d = 1'b0;
                    if (half_is_c(imem_rdata[31:16])) begin
                        emit       = 1'b1;
                        instr_d    = {16'h0, imem_rdata[31:16]};
                        instr_pc_d = fetch_addr_q + 32'd2;
                        hb_valid_d = 1'b0;
                        state_d    = S_EMIT;
                    end else begin
                        hb_valid_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (half_is_c(imem_rdata[15:0])) begin
                    emit       = 1'b1;
                    instr_d    = {16'h0, imem_rdata[15:0]};
                    instr_pc_d = fetch_addr_q;
                    hb_valid_d = 1'b1;
                    state_d    = S_EMIT;
                end else begin
                    emit       = 1'b1;
                    instr_d    = imem_rdata;
                    instr_pc_d = fetch_addr_q;
                    hb_valid_d = 1'b0;
                    state_d    = S_EMIT;
                end
            end
        end

        if (emit) begin
            instr_is_c_d = half_is_c(instr_d[15:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_NEXT;
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            pend_addr_q  <= {RESET_PC[31:2], 2'b00};
            hb_q         <= 16'h0;
            hb_pc_q      <= 32'h0;
            hb_valid_q   <= 1'b0;
            skip_low_q   <= RESET_PC[1];
            drop_q       <= 1'b0;
            instr_q      <= 32'h0;
            instr_pc_q   <= 32'h0;
            instr_is_c_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pend_addr_q  <= pend_addr_d;
            hb_q         <= hb_d;
            hb_pc_q      <= hb_pc_d;
            hb_valid_q   <= hb_valid_d;
            skip_low_q   <= skip_low_d;
            drop_q       <= drop_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            instr_is_c_q <= instr_is_c_d;
        end
    end

    assign imem_read   = (state_q == S_FETCH);
    assign imem_addr   = fetch_addr_q;
    assign instr_valid = (state_q == S_EMIT);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_is_c  = instr_is_c_q;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed bench for rvc_fetch_aligner: table of fetch streams plus hand-written redirect/backpressure sequences.
module tb_rvc_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_is_c;

    int tests = 0;
    int fails = 0;
    int lat   = 0;
    int nresp = 0;
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    rvc_fetch_aligner #(.RESET_PC(32'h00000060)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_read   (imem_read),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_is_c  (instr_is_c)
    );

    // Memory model: answers a held read in its (lat+1)-th cycle; unwritten words read as a nop.
    initial begin
        int cnt;
        cnt = 0;
        imem_resp = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            imem_resp = 1'b0;
            if (imem_read) begin
                if (cnt >= lat) begin
                    imem_resp = 1'b1;
                    imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 32'h00000013;
                    nresp++;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_read", {31'h0, imem_read}, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h60);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_instr_is_c", {31'h0, instr_is_c}, 32'h0);
        nresp = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_imem_read", {31'h0, imem_read}, 32'h1);
        chk("first_imem_addr", imem_addr, 32'h60);
    endtask

    // Returns at a negedge with instr_valid high; waited = idle negedges seen before it.
    task automatic wait_valid(output int waited);
        waited = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                waited = i;
                break;
            end
        end
        if (waited < 0) begin
            tests++;
            fails++;
            $display("FAIL valid_timeout: instr_valid low for 60 cycles, required high");
        end
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          reads;
        logic [31:0] nxt;
    } vec_t;

    typedef struct {
        int          vi;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        c;
        int          gap;
    } exp_t;

    vec_t vecs [4];
    exp_t exps [9];

    initial begin
        int g;
        int n0;

        vecs[0] = '{32'h00A00093, 32'h00000013, 1, 32'h64};
        vecs[1] = '{32'h45854505, 32'h00000013, 1, 32'h64};
        vecs[2] = '{32'h00934505, 32'h458500A0, 2, 32'h68};
        vecs[3] = '{32'hFFFF0001, 32'h1234ABCD, 2, 32'h68};

        exps[0] = '{0, 32'h00A00093, 32'h60, 1'b0, -1};
        exps[1] = '{1, 32'h00004505, 32'h60, 1'b1, -1};
        exps[2] = '{1, 32'h00004585, 32'h62, 1'b1,  0};
        exps[3] = '{2, 32'h00004505, 32'h60, 1'b1, -1};
        exps[4] = '{2, 32'h00A00093, 32'h62, 1'b0, -1};
        exps[5] = '{2, 32'h00004585, 32'h66, 1'b1,  0};
        exps[6] = '{3, 32'h00000001, 32'h60, 1'b1, -1};
        exps[7] = '{3, 32'hABCDFFFF, 32'h62, 1'b0, -1};
        exps[8] = '{3, 32'h00001234, 32'h66, 1'b1,  0};

        for (int v = 0; v < 4; v++) begin
            mem.delete();
            mem[32'h60] = vecs[v].w0;
            mem[32'h64] = vecs[v].w1;
            lat = 0;
            instr_ready = 1'b1;
            do_reset();
            for (int e = 0; e < 9; e++) begin
                if (exps[e].vi == v) begin
                    wait_valid(g);
                    chk($sformatf("v%0d_e%0d_instr", v, e), instr, exps[e].ins);
                    chk($sformatf("v%0d_e%0d_pc", v, e), instr_pc, exps[e].pc);
                    chk($sformatf("v%0d_e%0d_is_c", v, e), {31'h0, instr_is_c}, {31'h0, exps[e].c});
                    if (exps[e].gap >= 0)
                        chk($sformatf("v%0d_e%0d_gap", v, e), g, exps[e].gap);
                    @(posedge clk);
                    #1;
                end
            end
            chk($sformatf("v%0d_reads", v), nresp, vecs[v].reads);
            chk($sformatf("v%0d_next_read", v), {31'h0, imem_read}, 32'h1);
            chk($sformatf("v%0d_next_addr", v), imem_addr, vecs[v].nxt);
        end

        // Backpressure: five stalled cycles, accepted on the sixth.
        mem.delete();
        mem[32'h60] = 32'h00A00093;
        lat = 0;
        instr_ready = 1'b0;
        do_reset();
        wait_valid(g);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_valid", i), {31'h0, instr_valid}, 32'h1);
            chk($sformatf("bp%0d_instr", i), instr, 32'h00A00093);
            chk($sformatf("bp%0d_pc", i), instr_pc, 32'h60);
            chk($sformatf("bp%0d_is_c", i), {31'h0, instr_is_c}, 32'h0);
            chk($sformatf("bp%0d_no_read", i), {31'h0, imem_read}, 32'h0);
            @(negedge clk);
        end
        chk("bp6_valid", {31'h0, instr_valid}, 32'h1);
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_accepted", {31'h0, instr_valid}, 32'h0);
        chk("bp_next_addr", imem_addr, 32'h64);

        // Redirect to an odd halfword while an instruction is stalled.
        mem.delete();
        mem[32'h100] = 32'h4505FFFF;
        instr_ready = 1'b0;
        do_reset();
        wait_valid(g);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        n0 = nresp;
        @(negedge clk);
        redirect = 1'b0;
        chk("odd_valid_dropped", {31'h0, instr_valid}, 32'h0);
        chk("odd_read", {31'h0, imem_read}, 32'h1);
        chk("odd_addr", imem_addr, 32'h100);
        instr_ready = 1'b1;
        wait_valid(g);
        chk("odd_instr", instr, 32'h00004505);
        chk("odd_pc", instr_pc, 32'h102);
        chk("odd_is_c", {31'h0, instr_is_c}, 32'h1);
        chk("odd_reads", nresp - n0, 1);
        @(posedge clk);
        #1;
        chk("odd_next_addr", imem_addr, 32'h104);

        // Redirect while the 0x64 read is outstanding with 4-cycle latency.
        mem.delete();
        mem[32'h60]  = 32'h00A00093;
        mem[32'h64]  = 32'h45854505;
        mem[32'h200] = 32'h00C00113;
        lat = 3;
        instr_ready = 1'b1;
        do_reset();
        wait_valid(g);
        chk("drop_first_instr", instr, 32'h00A00093);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drop_pending_addr", imem_addr, 32'h64);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drop_hold%0d_read", i), {31'h0, imem_read}, 32'h1);
            chk($sformatf("drop_hold%0d_addr", i), imem_addr, 32'h64);
            chk($sformatf("drop_hold%0d_valid", i), {31'h0, instr_valid}, 32'h0);
            @(negedge clk);
        end
        chk("drop_new_read", {31'h0, imem_read}, 32'h1);
        chk("drop_new_addr", imem_addr, 32'h200);
        chk("drop_no_valid", {31'h0, instr_valid}, 32'h0);
        wait_valid(g);
        chk("drop_target_instr", instr, 32'h00C00113);
        chk("drop_target_pc", instr_pc, 32'h200);

        // Redirect on the same edge as an accept: the buffered 0x4585 must never appear.
        mem.delete();
        mem[32'h60]  = 32'h45854505;
        mem[32'h300] = 32'h00A00093;
        lat = 0;
        instr_ready = 1'b1;
        do_reset();
        wait_valid(g);
        chk("flush_first_instr", instr, 32'h00004505);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        chk("flush_valid_dropped", {31'h0, instr_valid}, 32'h0);
        wait_valid(g);
        chk("flush_target_instr", instr, 32'h00A00093);
        chk("flush_target_pc", instr_pc, 32'h300);
        chk("flush_target_is_c", {31'h0, instr_is_c}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
